// File: rtl/sap_buffer_register.sv
// SAP-1 controlled buffer register: a WIDTH-bit store that loads X on a rising
// CLK edge when LOAD is high and otherwise recirculates its contents. CLR is a
// synchronous active-high clear that takes priority over LOAD.
//
// Two cycle-identical implementations sit behind one top-level port list:
//   GATE_LEVEL = 1 : per bit, an AND-OR 2:1 mux gated by CLR feeding a D flip-flop
//   GATE_LEVEL = 0 : a single clocked process
//
// Optional build macro BUF_REG_BUS_OUT_EN adds a tri-state bus driver
// (input ENABLE, output W). W follows R while ENABLE is high and floats otherwise.

// Bare edge-triggered D flip-flop used as the storage cell of the gate-level version
module sap_buffer_register_dff (
   input  logic clk,
   input  logic d,
   output logic q
);

   // Capture D on every rising edge; clear and hold are resolved in front of D
   always_ff @(posedge clk) begin
      q <= d;
   end

endmodule

// Structural version: D_i = ((LOAD & X_i) | (~LOAD & R_i)) & ~CLR
module sap_buffer_register_gate #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] X,
   output logic [WIDTH-1:0] R
);

   logic             load_n;
   logic             clr_n;
   logic [WIDTH-1:0] r_q;

   not u_load_inv (load_n, LOAD);
   not u_clr_inv  (clr_n, CLR);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic take_x;
      logic keep_r;
      logic mux_out;
      logic d_in;

      and u_take (take_x, LOAD, X[i]);
      and u_keep (keep_r, load_n, r_q[i]);
      or  u_mux  (mux_out, take_x, keep_r);
      and u_clr  (d_in, mux_out, clr_n);

      sap_buffer_register_dff u_ff (
         .clk (CLK),
         .d   (d_in),
         .q   (r_q[i])
      );
   end

   assign R = r_q;

endmodule

// Behavioural version of the same register
module sap_buffer_register_beh #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] X,
   output logic [WIDTH-1:0] R
);

   // Clear beats load, load beats hold; everything resolves on the rising edge
   always_ff @(posedge CLK) begin
      if (CLR) begin
         R <= '0;
      end else if (LOAD) begin
         R <= X;
      end
   end

endmodule

// Top level: selects one implementation and optionally adds the bus driver
module sap_buffer_register #(
   parameter int WIDTH      = 4,
   parameter bit GATE_LEVEL = 1'b1
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] X,
`ifdef BUF_REG_BUS_OUT_EN
   input  logic             ENABLE,
   output tri   [WIDTH-1:0] W,
`endif
   output logic [WIDTH-1:0] R
);

   if (GATE_LEVEL) begin : g_gate
      sap_buffer_register_gate #(.WIDTH(WIDTH)) u_reg (
         .CLK  (CLK),
         .CLR  (CLR),
         .LOAD (LOAD),
         .X    (X),
         .R    (R)
      );
   end else begin : g_beh
      sap_buffer_register_beh #(.WIDTH(WIDTH)) u_reg (
         .CLK  (CLK),
         .CLR  (CLR),
         .LOAD (LOAD),
         .X    (X),
         .R    (R)
      );
   end

`ifdef BUF_REG_BUS_OUT_EN
   assign W = ENABLE ? R : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_sap_buffer_register.sv
// Directed bench for sap_buffer_register. Both implementations run side by side
// from the same stimulus and are checked against hand-computed values and
// against each other. Bus-driver checks are built only when BUF_REG_BUS_OUT_EN is defined.
module tb_sap_buffer_register;

   localparam int WIDTH = 4;

   logic             clk;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] r_gate;
   logic [WIDTH-1:0] r_beh;
`ifdef BUF_REG_BUS_OUT_EN
   logic             enable;
   tri   [WIDTH-1:0] w_gate;
   tri   [WIDTH-1:0] w_beh;
`endif

   int error_count;
   int check_count;

   sap_buffer_register #(.WIDTH(WIDTH), .GATE_LEVEL(1'b1)) dut_gate (
      .CLK    (clk),
      .CLR    (clr),
      .LOAD   (load),
      .X      (x),
`ifdef BUF_REG_BUS_OUT_EN
      .ENABLE (enable),
      .W      (w_gate),
`endif
      .R      (r_gate)
   );

   sap_buffer_register #(.WIDTH(WIDTH), .GATE_LEVEL(1'b0)) dut_beh (
      .CLK    (clk),
      .CLR    (clr),
      .LOAD   (load),
      .X      (x),
`ifdef BUF_REG_BUS_OUT_EN
      .ENABLE (enable),
      .W      (w_beh),
`endif
      .R      (r_beh)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if observed differs from expected
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   // Drive the inputs, then advance past one rising edge and settle
   task automatic applyStimulus(input logic c, input logic l, input logic [WIDTH-1:0] d);
      clr  = c;
      load = l;
      x    = d;
      @(posedge clk);
      #1;
   endtask

   // Both implementations must hold the same expected value
   task automatic checkBoth(input string tag, input logic [WIDTH-1:0] expected);
      checkOutput({tag, "_gate"}, r_gate, expected);
      checkOutput({tag, "_beh"}, r_beh, expected);
   endtask

   logic [WIDTH-1:0] exp_r;
   logic [4:0]       vec;

   initial begin
      error_count = 0;
      check_count = 0;
      clr  = 1'b0;
      load = 1'b0;
      x    = '0;
`ifdef BUF_REG_BUS_OUT_EN
      enable = 1'b0;
`endif
      #1;

      // Reset: clear wins over a pending load of F
      applyStimulus(1'b1, 1'b1, 4'hF);
      checkBoth("reset", 4'h0);

      // Load A: nothing changes before the edge, A appears after it
      clr  = 1'b0;
      load = 1'b1;
      x    = 4'hA;
      #2;
      checkBoth("preedge", 4'h0);
      applyStimulus(1'b0, 1'b1, 4'hA);
      checkBoth("load_a", 4'hA);

      // Hold: LOAD low, X swept through every value, R stays A
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 4'(i));
         checkBoth("hold", 4'hA);
      end

      // Sweep {X,LOAD}: odd codes load X, even codes keep the previous value
      exp_r = 4'hA;
      for (int i = 0; i < 32; i++) begin
         vec = 5'(i);
         if (vec[0]) exp_r = vec[4:1];
         for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, vec[0], vec[4:1]);
            checkBoth("sweep", exp_r);
            checkOutput("sweep_equiv", r_gate, r_beh);
         end
      end

      // Clear priority: from 7, clear with LOAD=1/X=9 gives 0, then 9 loads
      applyStimulus(1'b0, 1'b1, 4'h7);
      checkBoth("pre_clr", 4'h7);
      applyStimulus(1'b1, 1'b1, 4'h9);
      checkBoth("clr_prio", 4'h0);
      applyStimulus(1'b0, 1'b1, 4'h9);
      checkBoth("post_clr", 4'h9);

      // Tracking: LOAD held high, R follows X one edge later
      applyStimulus(1'b0, 1'b1, 4'h3);
      checkBoth("track_3", 4'h3);
      applyStimulus(1'b0, 1'b1, 4'hC);
      checkBoth("track_c", 4'hC);

`ifdef BUF_REG_BUS_OUT_EN
      // Bus driver: float while disabled, follow R while enabled, R untouched
      applyStimulus(1'b0, 1'b1, 4'h5);
      load   = 1'b0;
      enable = 1'b0;
      #1;
      checkOutput("bus_off_gate", w_gate, 4'bzzzz);
      checkOutput("bus_off_beh", w_beh, 4'bzzzz);
      enable = 1'b1;
      #1;
      checkOutput("bus_on_gate", w_gate, 4'h5);
      checkOutput("bus_on_beh", w_beh, 4'h5);
      checkBoth("bus_r", 4'h5);
`endif

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule

// File: doc/sap_buffer_register.md
Name: sap_buffer_register

Overview:
- SAP-1 controlled buffer register (textbook fig. 8-2): a WIDTH-bit register that captures input word X on a clock edge when LOAD is high, and otherwise recirculates its stored value.
- Used as the generic load-controlled storage element for SAP-1 registers (accumulator, B, output, MAR/IR building block).
- Two equivalent implementations are delivered with identical ports and cycle behaviour:
  - a structural gate-level version: per bit, an AND-OR 2:1 multiplexer feeding a D flip-flop;
  - a behavioural version.

Parameters:
- WIDTH, 4, data width of X and R in bits (must be >= 1).

Ports:
- CLK, input, 1, system clock; all state changes on the rising edge.
- CLR, input, 1, synchronous active-high clear.
- LOAD, input, 1, load enable; 1 = capture X, 0 = hold.
- X, input, WIDTH, data word to be loaded.
- R, output, WIDTH, registered contents (flip-flop Q outputs, no combinational path from inputs).

Behaviour:
- One clock; reset is synchronous and active-high (CLK, CLR).
- Evaluation happens only at the rising edge of CLK, in priority order:
  - CLR=1 -> R <= 0 (all bits), regardless of LOAD and X.
  - CLR=0, LOAD=1 -> R <= X.
  - CLR=0, LOAD=0 -> R <= R (hold).
- Latency: exactly one rising edge from a sampled LOAD/X to updated R; no change between edges.
- Reset value of R: all zeros after the first rising edge with CLR=1. Value before any reset edge is unspecified (X in simulation).
- CLR asserted mid-operation (during a LOAD) wins that edge; the load is discarded.
- Inputs changing between edges have no effect; only values at the edge matter.
- LOAD held high -> R tracks X delayed by one cycle every cycle.
- X/Z on LOAD in simulation: unspecified; benches drive known values.
- Gate-level version structure, per bit i:
  - D_i = (LOAD AND X_i) OR (NOT LOAD AND R_i);
  - a synchronous clear forces D_i to 0 when CLR=1;
  - edge-triggered D flip-flop per bit, generated over WIDTH;
  - no behavioural always blocks except the primitive flip-flop.
- Behavioural version: a single clocked process implementing the priority list above.
- Both versions are cycle-identical for all stimulus after the first reset edge.

Optional Feature:
- Macro: BUF_REG_BUS_OUT_EN.
- Defined:
  - adds input ENABLE (1 bit) and output W (WIDTH bits);
  - W = R when ENABLE=1, high-impedance when ENABLE=0 (tri-state bus driver, combinational from ENABLE/R);
  - R is unaffected by ENABLE.
- Undefined: ENABLE and W do not exist; port list is exactly as above.

Test Plan:
- Reset: CLR=1 across one rising edge with LOAD=1, X=4'hF -> R=4'h0 after that edge, both versions.
- Load: CLR=0, LOAD=1, X=4'hA -> R=4'hA after the next rising edge; no change before the edge.
- Hold: after R=4'hA, set LOAD=0 and sweep X through 0..F over several cycles -> R stays 4'hA.
- Exhaustive sweep: drive {X,LOAD}=i for i=0..31, each held several clock periods -> R updates to X only on odd i (LOAD=1) and holds on even i; gate-level R equals behavioural R every cycle.
- Clear priority: R=4'h7, assert CLR=1 with LOAD=1, X=4'h9 for one edge -> R=4'h0; release CLR -> next edge loads 4'h9.
- Optional bus output (BUF_REG_BUS_OUT_EN defined): R=4'h5, ENABLE=0 -> W=4'bzzzz; ENABLE=1 -> W=4'h5 combinationally.
